// File: rtl/psk_demap_deframer.sv
// PSK symbol slicer, sync-word hunter and payload byte deframer with an AXI-Stream byte output.
// Optional feature: define PSK_AMBIG_RESOLVE_EN to also lock on the inverted sync word (180-degree ambiguity).
module psk_demap_deframer #(
  parameter int          WIDTH      = 12,
  parameter logic [15:0] SYNC_WORD  = 16'hEB90,
  parameter int          SYNC_LEN   = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                    clk_32d768M,
  input  logic                    rst_32d768M,
  input  logic signed [WIDTH-1:0] sym_I,
  input  logic signed [WIDTH-1:0] sym_Q,
  input  logic                    sym_valid,
  input  logic                    RX_IS_BPSK,
  input  logic [7:0]              FRAME_LEN,
  output logic [7:0]              psk_tdata,
  output logic                    psk_tvalid,
  input  logic                    psk_tready,
  output logic                    psk_tlast,
  output logic                    psk_tuser,
  output logic                    frame_locked,
  output logic                    overflow,
  output logic [15:0]             frame_cnt
);

  localparam int                  AW       = $clog2(FIFO_DEPTH);
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  function automatic logic slice_bit(input logic signed [WIDTH-1:0] x);
    return (x < 0);
  endfunction

  state_t              state, state_nxt;
  logic [SYNC_LEN-2:0] hist, hist_nxt;
  logic [7:0]          sr, sr_nxt;
  logic [2:0]          bcnt, bcnt_nxt;
  logic [7:0]          bidx, bidx_nxt;
  logic                bpsk_lat, bpsk_nxt;
  logic [7:0]          flen_lat, flen_nxt;

  logic                b0, b1, pb0, pb1, flag_cur;
  logic [SYNC_LEN-1:0] win_i, win_q;
  logic                m_i_t, m_q_t, m_i_n, m_q_n;
  logic                lock_i, lock_q, lock_inv;
  logic                cmpl, cmpl_last;
  logic [7:0]          cbyte;

  logic                vld_p1, last_p1, user_p1;
  logic [7:0]          byte_p1;

`ifdef PSK_AMBIG_RESOLVE_EN
  logic inv_flag;
`endif

  // ---- p0: slice the incoming symbol, hunt for sync, assemble payload bits
  always_comb begin
    b0    = slice_bit(sym_I);
    b1    = slice_bit(sym_Q);
    win_i = {hist, b0};
    win_q = {win_i[SYNC_LEN-2:0], b1};
    m_i_t = (win_i == SYNC_PAT);
    m_q_t = (win_q == SYNC_PAT);
`ifdef PSK_AMBIG_RESOLVE_EN
    m_i_n    = (win_i == ~SYNC_PAT);
    m_q_n    = (win_q == ~SYNC_PAT);
    flag_cur = inv_flag;
`else
    m_i_n    = 1'b0;
    m_q_n    = 1'b0;
    flag_cur = 1'b0;
`endif
    // The I-bit window is checked first so that the earlier match wins.
    lock_i   = m_i_t | m_i_n;
    lock_q   = !RX_IS_BPSK && !lock_i && (m_q_t | m_q_n);
    lock_inv = lock_i ? !m_i_t : !m_q_t;
    pb0      = b0 ^ flag_cur;
    pb1      = b1 ^ flag_cur;

    state_nxt = state;
    hist_nxt  = hist;
    sr_nxt    = sr;
    bcnt_nxt  = bcnt;
    bidx_nxt  = bidx;
    bpsk_nxt  = bpsk_lat;
    flen_nxt  = flen_lat;
    cmpl      = 1'b0;
    cmpl_last = 1'b0;
    cbyte     = sr;

    if (sym_valid) begin
      if (state == HUNT) begin
        hist_nxt = RX_IS_BPSK ? win_i[SYNC_LEN-2:0] : win_q[SYNC_LEN-2:0];
        if (lock_i || lock_q) begin
          state_nxt = PAYLOAD;
          hist_nxt  = '0;
          bpsk_nxt  = RX_IS_BPSK;
          flen_nxt  = FRAME_LEN;
          bidx_nxt  = 8'd0;
          if (lock_i && !RX_IS_BPSK) begin
            sr_nxt   = {7'd0, b1 ^ lock_inv};
            bcnt_nxt = 3'd1;
          end else begin
            sr_nxt   = 8'd0;
            bcnt_nxt = 3'd0;
          end
        end
      end else begin
        if (bpsk_lat) begin
          sr_nxt   = {sr[6:0], pb0};
          bcnt_nxt = bcnt + 3'd1;
          cmpl     = (bcnt == 3'd7);
          cbyte    = {sr[6:0], pb0};
        end else if (bcnt == 3'd7) begin
          // Byte closes on the I bit; the Q bit opens the next byte.
          cmpl     = 1'b1;
          cbyte    = {sr[6:0], pb0};
          sr_nxt   = {7'd0, pb1};
          bcnt_nxt = 3'd1;
        end else if (bcnt == 3'd6) begin
          cmpl     = 1'b1;
          cbyte    = {sr[5:0], pb0, pb1};
          sr_nxt   = 8'd0;
          bcnt_nxt = 3'd0;
        end else begin
          sr_nxt   = {sr[5:0], pb0, pb1};
          bcnt_nxt = bcnt + 3'd2;
        end
        if (cmpl) begin
          cmpl_last = (bidx == flen_lat - 8'd1);
          bidx_nxt  = bidx + 8'd1;
          if (cmpl_last) begin
            state_nxt = HUNT;
            hist_nxt  = '0;
            sr_nxt    = 8'd0;
            bcnt_nxt  = 3'd0;
          end
        end
      end
    end
  end

  // ---- p0 -> p1: framing state and the completed byte
  always_ff @(posedge clk_32d768M or posedge rst_32d768M) begin
    if (rst_32d768M) begin
      state        <= HUNT;
      hist         <= '0;
      sr           <= 8'd0;
      bcnt         <= 3'd0;
      bidx         <= 8'd0;
      bpsk_lat     <= 1'b0;
      flen_lat     <= 8'd0;
      frame_locked <= 1'b0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      user_p1      <= 1'b0;
      byte_p1      <= 8'd0;
    end else begin
      state        <= state_nxt;
      hist         <= hist_nxt;
      sr           <= sr_nxt;
      bcnt         <= bcnt_nxt;
      bidx         <= bidx_nxt;
      bpsk_lat     <= bpsk_nxt;
      flen_lat     <= flen_nxt;
      frame_locked <= (state_nxt == PAYLOAD);
      vld_p1       <= cmpl;
      if (cmpl) begin
        byte_p1 <= cbyte;
        last_p1 <= cmpl_last;
        user_p1 <= bpsk_lat;
      end
    end
  end

`ifdef PSK_AMBIG_RESOLVE_EN
  always_ff @(posedge clk_32d768M or posedge rst_32d768M) begin
    if (rst_32d768M) begin
      inv_flag <= 1'b0;
    end else if (state == HUNT) begin
      inv_flag <= sym_valid && (lock_i || lock_q) && lock_inv;
    end else if (state_nxt == HUNT) begin
      inv_flag <= 1'b0;
    end
  end
`endif

  // ---- p1 -> p2: byte FIFO; its head drives the stream outputs
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt, fcnt_nxt;
  logic          rd_en, wr_en;

  assign rd_en = psk_tvalid & psk_tready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en = vld_p1 & ((fcnt != FULL_CNT) | rd_en);
  assign {psk_tlast, psk_tuser, psk_tdata} = mem[rd_ptr];

  always_comb begin
    fcnt_nxt = fcnt;
    case ({wr_en, rd_en})
      2'b10:   fcnt_nxt = fcnt + 1'b1;
      2'b01:   fcnt_nxt = fcnt - 1'b1;
      default: fcnt_nxt = fcnt;
    endcase
  end

  always_ff @(posedge clk_32d768M or posedge rst_32d768M) begin
    if (rst_32d768M) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 10'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcnt       <= '0;
      psk_tvalid <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {last_p1, user_p1, byte_p1};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      fcnt       <= fcnt_nxt;
      psk_tvalid <= (fcnt_nxt != '0);
      if (vld_p1 && !wr_en) overflow <= 1'b1;
      if (vld_p1 && last_p1) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_psk_demap_deframer.sv
// Directed bench for psk_demap_deframer with a beat scoreboard; follows PSK_AMBIG_RESOLVE_EN if defined.
module tb_psk_demap_deframer;

  localparam int WIDTH = 12;

  logic                    clk_32d768M = 1'b0;
  logic                    rst_32d768M = 1'b1;
  logic signed [WIDTH-1:0] sym_I = '0;
  logic signed [WIDTH-1:0] sym_Q = '0;
  logic                    sym_valid = 1'b0;
  logic                    RX_IS_BPSK = 1'b1;
  logic [7:0]              FRAME_LEN = 8'd3;
  logic [7:0]              psk_tdata;
  logic                    psk_tvalid;
  logic                    psk_tready = 1'b1;
  logic                    psk_tlast;
  logic                    psk_tuser;
  logic                    frame_locked;
  logic                    overflow;
  logic [15:0]             frame_cnt;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t exp_q[$];
  logic  bitq[$];
  int    checks   = 0;
  int    failures = 0;
  logic  tog      = 1'b0;

  always #5 clk_32d768M = ~clk_32d768M;

  psk_demap_deframer dut (
    .clk_32d768M (clk_32d768M),
    .rst_32d768M (rst_32d768M),
    .sym_I       (sym_I),
    .sym_Q       (sym_Q),
    .sym_valid   (sym_valid),
    .RX_IS_BPSK  (RX_IS_BPSK),
    .FRAME_LEN   (FRAME_LEN),
    .psk_tdata   (psk_tdata),
    .psk_tvalid  (psk_tvalid),
    .psk_tready  (psk_tready),
    .psk_tlast   (psk_tlast),
    .psk_tuser   (psk_tuser),
    .frame_locked(frame_locked),
    .overflow    (overflow),
    .frame_cnt   (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic signed [WIDTH-1:0] amp(input logic b);
    logic signed [WIDTH-1:0] v;
    v = WIDTH'($urandom_range(1, 2047));
    return b ? -v : v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_32d768M);
      #1;
      if (tog) psk_tready = ~psk_tready;
    end
  endtask

  task automatic send_sym(input logic bi, input logic bq, input logic neg);
    sym_I     = neg ? -amp(bi) : amp(bi);
    sym_Q     = neg ? -amp(bq) : amp(bq);
    sym_valid = 1'b1;
    @(posedge clk_32d768M);
    #1;
    sym_valid = 1'b0;
    if (tog) psk_tready = ~psk_tready;
  endtask

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic flush_bpsk(input logic neg);
    while (bitq.size() != 0) send_sym(bitq.pop_front(), 1'b0, neg);
  endtask

  task automatic flush_qpsk();
    logic a, b;
    while (bitq.size() != 0) begin
      a = bitq.pop_front();
      b = (bitq.size() != 0) ? bitq.pop_front() : 1'b0;
      send_sym(a, b, 1'b0);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b.d = d;
    b.l = l;
    b.u = u;
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      idle(1);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_32d768M = 1'b1;
    idle(3);
    rst_32d768M = 1'b0;
    idle(1);
  endtask

  // Scoreboard: each accepted beat is matched against the oldest expected beat;
  // a stalled beat must stay put until it is taken.
  initial begin
    beat_t e;
    logic  stall_prev = 1'b0;
    logic [9:0] held = '0;
    forever begin
      @(negedge clk_32d768M);
      if (rst_32d768M) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_tvalid", psk_tvalid, 1'b1);
          chk("stall_hold", {psk_tlast, psk_tuser, psk_tdata}, held);
        end
        if (psk_tvalid && psk_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {psk_tlast, psk_tuser, psk_tdata}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", psk_tdata, e.d);
            chk("beat_tlast", psk_tlast, e.l);
            chk("beat_tuser", psk_tuser, e.u);
          end
        end
        stall_prev = psk_tvalid && !psk_tready;
        held       = {psk_tlast, psk_tuser, psk_tdata};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;

    // Reset state
    @(posedge clk_32d768M);
    #1;
    chk("rst_tvalid", psk_tvalid, 0);
    chk("rst_tdata", psk_tdata, 0);
    chk("rst_tlast", psk_tlast, 0);
    chk("rst_tuser", psk_tuser, 0);
    chk("rst_locked", frame_locked, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_32d768M = 1'b0;
    idle(2);

    // T1: BPSK, three bytes
    RX_IS_BPSK = 1'b1;
    FRAME_LEN  = 8'd3;
    push_bits(16'hEB90, 16);
    flush_bpsk(1'b0);
    chk("t1_locked", frame_locked, 1);
    push_exp(8'h12, 1'b0, 1'b1);
    push_exp(8'h34, 1'b0, 1'b1);
    push_exp(8'h56, 1'b1, 1'b1);
    push_bits(16'h1234, 16);
    push_bits(16'h0056, 8);
    flush_bpsk(1'b0);
    chk("t1_lat_before", psk_tvalid, 0);
    idle(1);
    chk("t1_lat_tvalid", psk_tvalid, 1);
    chk("t1_lat_tdata", psk_tdata, 8'h56);
    wait_drain("t1_drained", 50);
    idle(2);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_unlocked", frame_locked, 0);
    chk("t1_tvalid_idle", psk_tvalid, 0);

    // T2: QPSK, one junk bit so sync ends on an I bit
    RX_IS_BPSK = 1'b0;
    FRAME_LEN  = 8'd2;
    push_bits(16'h0000, 1);
    push_bits(16'hEB90, 16);
    push_bits(16'hA53C, 16);
    push_bits(16'h0000, 1);
    push_exp(8'hA5, 1'b0, 1'b0);
    push_exp(8'h3C, 1'b1, 1'b0);
    flush_qpsk();
    wait_drain("t2_drained", 50);
    idle(2);
    chk("t2_frame_cnt", frame_cnt, 2);
    chk("t2_unlocked", frame_locked, 0);

    // T3: BPSK, eight bytes into a stalled sink
    chk("t3_overflow_pre", overflow, 0);
    RX_IS_BPSK = 1'b1;
    FRAME_LEN  = 8'd8;
    psk_tready = 1'b0;
    push_bits(16'hEB90, 16);
    for (int i = 0; i < 8; i++) begin
      v = 8'h3A ^ 8'(i * 17);
      if (i < 4) push_exp(v, 1'b0, 1'b1);
      push_bits({8'h00, v}, 8);
    end
    flush_bpsk(1'b0);
    idle(4);
    chk("t3_overflow", overflow, 1);
    chk("t3_tvalid", psk_tvalid, 1);
    chk("t3_head", psk_tdata, 8'h3A);
    chk("t3_frame_cnt", frame_cnt, 3);
    chk("t3_unlocked", frame_locked, 0);
    psk_tready = 1'b1;
    wait_drain("t3_drained", 50);
    idle(2);
    chk("t3_tvalid_drop", psk_tvalid, 0);

    // T4: reset in the middle of a frame
    FRAME_LEN  = 8'd4;
    psk_tready = 1'b0;
    push_bits(16'hEB90, 16);
    push_bits(16'h1122, 16);
    flush_bpsk(1'b0);
    idle(3);
    chk("t4_locked_pre", frame_locked, 1);
    chk("t4_tvalid_pre", psk_tvalid, 1);
    chk("t4_overflow_pre", overflow, 1);
    chk("t4_frame_cnt_pre", frame_cnt, 3);
    rst_32d768M = 1'b1;
    #1;
    chk("t4_rst_tvalid", psk_tvalid, 0);
    chk("t4_rst_tdata", psk_tdata, 0);
    chk("t4_rst_tlast", psk_tlast, 0);
    chk("t4_rst_tuser", psk_tuser, 0);
    chk("t4_rst_locked", frame_locked, 0);
    chk("t4_rst_overflow", overflow, 0);
    chk("t4_rst_frame_cnt", frame_cnt, 0);
    idle(2);
    rst_32d768M = 1'b0;
    psk_tready  = 1'b1;
    idle(1);
    push_bits(16'hEB90, 16);
    push_bits(16'h9ABC, 16);
    push_bits(16'hDEF0, 16);
    push_exp(8'h9A, 1'b0, 1'b1);
    push_exp(8'hBC, 1'b0, 1'b1);
    push_exp(8'hDE, 1'b0, 1'b1);
    push_exp(8'hF0, 1'b1, 1'b1);
    flush_bpsk(1'b0);
    wait_drain("t4_drained", 50);
    idle(2);
    chk("t4_frame_cnt", frame_cnt, 1);
    chk("t4_overflow", overflow, 0);

    // T6: FRAME_LEN=0 (256 bytes) with tready toggling every cycle
    FRAME_LEN  = 8'd0;
    psk_tready = 1'b1;
    tog        = 1'b1;
    push_bits(16'hEB90, 16);
    flush_bpsk(1'b0);
    for (int i = 0; i < 256; i++) begin
      v = 8'(i) ^ 8'h5C;
      push_exp(v, (i == 255), 1'b1);
      push_bits({8'h00, v}, 8);
      flush_bpsk(1'b0);
    end
    wait_drain("t6_drained", 300);
    tog        = 1'b0;
    psk_tready = 1'b1;
    idle(2);
    chk("t6_frame_cnt", frame_cnt, 2);
    chk("t6_overflow", overflow, 0);
    chk("t6_tvalid_idle", psk_tvalid, 0);

    // T5: every sample negated (180-degree rotation)
    do_reset();
    RX_IS_BPSK = 1'b1;
    FRAME_LEN  = 8'd1;
    push_bits(16'hEB90, 16);
    flush_bpsk(1'b1);
`ifdef PSK_AMBIG_RESOLVE_EN
    chk("t5_locked", frame_locked, 1);
    push_exp(8'h0F, 1'b1, 1'b1);
`else
    chk("t5_no_lock", frame_locked, 0);
`endif
    push_bits(16'h000F, 8);
    flush_bpsk(1'b1);
    wait_drain("t5_drained", 50);
    idle(4);
`ifdef PSK_AMBIG_RESOLVE_EN
    chk("t5_frame_cnt", frame_cnt, 1);
`else
    chk("t5_frame_cnt", frame_cnt, 0);
    chk("t5_still_unlocked", frame_locked, 0);
    chk("t5_tvalid", psk_tvalid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
